// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared constants and types for the delta-sigma decimation path
package dsm_pkg;

   localparam int CIC_ORDER = 3;

   // Integrator/comb width needed for bit growth of an order-3 CIC with unit differential delay.
   function automatic int cic_acc_width(input int decim);
      return CIC_ORDER * $clog2(decim) + 2;
   endfunction

   localparam int ACC_W_DEFAULT = cic_acc_width(64);

   typedef logic signed [ACC_W_DEFAULT-1:0] cic_acc_t;

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one registered comb section, out = in - previous in
module cic_comb_stage #(
   parameter int WIDTH = 20
) (
   input  logic                    aclk,
   input  logic                    arst_n,
   input  logic signed [WIDTH-1:0] in_tdata,
   input  logic                    in_tvalid,
   output logic signed [WIDTH-1:0] out_tdata,
   output logic                    out_tvalid
);

   logic signed [WIDTH-1:0] delay_q;

   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         delay_q    <= '0;
         out_tdata  <= '0;
         out_tvalid <= 1'b0;
      end else begin
         out_tvalid <= in_tvalid;
         if (in_tvalid) begin
            out_tdata <= in_tdata - delay_q;
            delay_q   <= in_tdata;
         end
      end
   end

endmodule

// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - third-order CIC decimator for a 1-bit modulator stream
module cic_decimator
   import dsm_pkg::*;
#(
   parameter int DECIM     = 64,
   parameter int OUT_WIDTH = 16
) (
   input  logic                        aclk,
   input  logic                        arst_n,
   input  logic                        s_axis_data_tdata,
   input  logic                        s_axis_data_tvalid,
   output logic                        s_axis_data_tready,
   output logic signed [OUT_WIDTH-1:0] m_axis_data_tdata,
   output logic                        m_axis_data_tvalid,
   input  logic                        m_axis_data_tready,
   output logic                        settled,
   output logic                        overrun
);

   localparam int ACC_W = cic_acc_width(DECIM);
   localparam int CNT_W = $clog2(DECIM);

   typedef logic signed [ACC_W-1:0] acc_t;

   acc_t                 integ [CIC_ORDER];
   acc_t                 x;
   logic [CNT_W-1:0]     phase;
   logic                 tick_q;
   acc_t                 comb_data  [CIC_ORDER+1];
   logic                 comb_valid [CIC_ORDER+1];
   logic signed [OUT_WIDTH-1:0] scaled;
   logic [1:0]           produced;

   assign s_axis_data_tready = arst_n;
   assign x = s_axis_data_tdata ? acc_t'(1) : acc_t'(-1);

   // Integrators run at the input rate and wrap freely; the combs undo the wrap.
   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         for (int k = 0; k < CIC_ORDER; k++) integ[k] <= '0;
         phase  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= s_axis_data_tvalid && (phase == CNT_W'(DECIM - 1));
         if (s_axis_data_tvalid) begin
            phase    <= phase + 1'b1;
            integ[0] <= integ[0] + x;
            for (int k = 1; k < CIC_ORDER; k++) integ[k] <= integ[k] + integ[k-1];
         end
      end
   end

   assign comb_data[0]  = integ[CIC_ORDER-1];
   assign comb_valid[0] = tick_q;

   for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
      cic_comb_stage #(
         .WIDTH(ACC_W)
      ) u_comb (
         .aclk      (aclk),
         .arst_n    (arst_n),
         .in_tdata  (comb_data[g]),
         .in_tvalid (comb_valid[g]),
         .out_tdata (comb_data[g+1]),
         .out_tvalid(comb_valid[g+1])
      );
   end

   if (ACC_W > OUT_WIDTH) begin : g_shift
      assign scaled = OUT_WIDTH'(comb_data[CIC_ORDER] >>> (ACC_W - OUT_WIDTH));
   end else begin : g_extend
      assign scaled = OUT_WIDTH'(comb_data[CIC_ORDER]);
   end

   // Output holds while stalled; a sample arriving into a stalled slot is dropped.
   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         m_axis_data_tdata  <= '0;
         m_axis_data_tvalid <= 1'b0;
         settled            <= 1'b0;
         overrun            <= 1'b0;
         produced           <= '0;
      end else if (comb_valid[CIC_ORDER]) begin
         if (produced != 2'd3) produced <= produced + 2'd1;
         if (produced == 2'd2) settled <= 1'b1;
         if (!m_axis_data_tvalid || m_axis_data_tready) begin
            m_axis_data_tdata  <= scaled;
            m_axis_data_tvalid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (m_axis_data_tvalid && m_axis_data_tready) begin
         m_axis_data_tvalid <= 1'b0;
      end
   end

endmodule
